pe_result_collector: RTL and testbench



---
 rtl/pe_pkg.sv | 56 +++++
 rtl/pe_result_classify.sv | 56 +++++
 rtl/pe_result_collector.sv | 115 +++++++++++
 tb/tb_pe_result_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared encodings and field layout for PE result collection.
// Mode tags, class bit indices, per-format field positions.
package pe_pkg;

  localparam logic [1:0] MODE_FP16 = 2'b00;
  localparam logic [1:0] MODE_FP32 = 2'b01;
  localparam logic [1:0] MODE_FP64 = 2'b10;
  localparam logic [1:0] MODE_BF16 = 2'b11;

  localparam int CLS_ZERO = 0;
  localparam int CLS_INF  = 1;
  localparam int CLS_NAN  = 2;
  localparam int CLS_NEG  = 3;

  localparam int FP16_SIGN    = 15;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;

  localparam int BF16_SIGN    = 15;
  localparam int BF16_EXP_LSB = 7;
  localparam int BF16_EXP_W   = 8;
  localparam int BF16_MAN_W   = 7;

  localparam int FP32_SIGN    = 31;
  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_EXP_W   = 8;
  localparam int FP32_MAN_W   = 23;

  localparam int FP64_SIGN    = 63;
  localparam int FP64_EXP_LSB = 52;
  localparam int FP64_EXP_W   = 11;
  localparam int FP64_MAN_W   = 52;

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  cls;
    logic [63:0] data;
  } res_t;

  function automatic logic [3:0] mk_class(
    input logic sgn,
    input logic exp_ones,
    input logic exp_zero,
    input logic man_zero
  );
    logic [3:0] c;
    c           = '0;
    c[CLS_NEG]  = sgn;
    c[CLS_NAN]  = exp_ones & ~man_zero;
    c[CLS_INF]  = exp_ones & man_zero;
    c[CLS_ZERO] = exp_zero & man_zero;
    return c;
  endfunction

endpackage

// File: rtl/pe_result_classify.sv
// Combinational precision mask and class extraction.
// Upper bits beyond the issued format are forced to zero.
module pe_result_classify
  import pe_pkg::*;
(
  input  logic [1:0]  i_mode,
  input  logic [63:0] i_word,
  output logic [63:0] o_data,
  output logic [3:0]  o_cls
);

  logic w_sgn;
  logic w_eo;
  logic w_ez;
  logic w_mz;

  always_comb begin
    o_data = '0;
    w_sgn  = 1'b0;
    w_eo   = 1'b0;
    w_ez   = 1'b0;
    w_mz   = 1'b0;
    unique case (1'b1)
      (i_mode == MODE_FP64): begin
        o_data = i_word;
        w_sgn  = i_word[FP64_SIGN];
        w_eo   = &i_word[FP64_EXP_LSB +: FP64_EXP_W];
        w_ez   = ~|i_word[FP64_EXP_LSB +: FP64_EXP_W];
        w_mz   = ~|i_word[0 +: FP64_MAN_W];
      end
      (i_mode == MODE_FP32): begin
        o_data[31:0] = i_word[31:0];
        w_sgn  = i_word[FP32_SIGN];
        w_eo   = &i_word[FP32_EXP_LSB +: FP32_EXP_W];
        w_ez   = ~|i_word[FP32_EXP_LSB +: FP32_EXP_W];
        w_mz   = ~|i_word[0 +: FP32_MAN_W];
      end
      (i_mode == MODE_BF16): begin
        o_data[15:0] = i_word[15:0];
        w_sgn  = i_word[BF16_SIGN];
        w_eo   = &i_word[BF16_EXP_LSB +: BF16_EXP_W];
        w_ez   = ~|i_word[BF16_EXP_LSB +: BF16_EXP_W];
        w_mz   = ~|i_word[0 +: BF16_MAN_W];
      end
      default: begin
        o_data[15:0] = i_word[15:0];
        w_sgn  = i_word[FP16_SIGN];
        w_eo   = &i_word[FP16_EXP_LSB +: FP16_EXP_W];
        w_ez   = ~|i_word[FP16_EXP_LSB +: FP16_EXP_W];
        w_mz   = ~|i_word[0 +: FP16_MAN_W];
      end
    endcase
    o_cls = mk_class(w_sgn, w_eo, w_ez, w_mz);
  end

endmodule

// File: rtl/pe_result_collector.sv
// Tracks PE issues through its fixed latency, captures,
// masks and classifies results into a valid/ready FIFO.
module pe_result_collector
  import pe_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_mode,
  input  logic [63:0]              pe_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic [1:0]               res_mode,
  output logic [3:0]               res_class,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [LATENCY-1:0] r_trk_v;
  logic [1:0]         r_trk_m [LATENCY];

  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_cnt;
  logic               r_drop;
  res_t               r_mem [DEPTH];

  logic               w_cap;
  logic [1:0]         w_cap_mode;
  logic [63:0]        w_cap_data;
  logic [3:0]         w_cap_cls;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  res_t               w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trk_v <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_trk_m[i] <= '0;
    end else begin
      r_trk_v[0] <= issue_valid;
      r_trk_m[0] <= issue_mode;
      for (int i = 1; i < LATENCY; i++) begin
        r_trk_v[i] <= r_trk_v[i-1];
        r_trk_m[i] <= r_trk_m[i-1];
      end
    end
  end

  assign w_cap      = r_trk_v[LATENCY-1];
  assign w_cap_mode = r_trk_m[LATENCY-1];

  pe_result_classify u_cls (
    .i_mode (w_cap_mode),
    .i_word (pe_out),
    .o_data (w_cap_data),
    .o_cls  (w_cap_cls)
  );

  // A full FIFO still accepts a capture if the head leaves this cycle.
  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_pop  = res_valid && res_ready;
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wp] <= '{mode: w_cap_mode,
                       cls:  w_cap_cls,
                       data: w_cap_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CW'(1);
      if (w_drop)
        r_drop <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rp];
  assign res_valid = (r_cnt != '0);
  assign res_data  = res_valid ? w_head.data : '0;
  assign res_mode  = res_valid ? w_head.mode : '0;
  assign res_class = res_valid ? w_head.cls  : '0;
  assign count     = r_cnt;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector with a
// fixed two-cycle PE stand-in driving pe_out.
module tb_pe_result_collector;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [1:0]  issue_mode;
  logic [63:0] pe_out;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [1:0]  res_mode;
  logic [3:0]  res_class;
  logic [2:0]  count;
  logic        drop_err;

  logic [63:0] issue_val;
  logic [63:0] r_pv0;
  logic [63:0] r_pv1;

  int n_chk;
  int n_fail;

  pe_result_collector #(.LATENCY(2), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_mode  (issue_mode),
    .pe_out      (pe_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_mode    (res_mode),
    .res_class   (res_class),
    .count       (count),
    .drop_err    (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE stand-in: result appears two cycles after its issue.
  always @(posedge clk) begin
    r_pv0 <= issue_val;
    r_pv1 <= r_pv0;
  end
  assign pe_out = r_pv1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] m, input logic [63:0] v);
    issue_valid = 1'b1;
    issue_mode  = m;
    issue_val   = v;
    step();
    issue_valid = 1'b0;
    issue_mode  = 2'b00;
    issue_val   = '0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    res_ready   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [75:0] got;
    do_reset();
    got = {res_valid, res_data, res_mode, res_class, count, drop_err};
    n_chk++;
    if (got !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
  endtask

  task automatic test_fp32_sign();
    logic [70:0] got;
    logic [70:0] exp;
    do_reset();
    do_issue(2'b01, 64'hFFFF_FFFF_C328_0000);
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_issue1 res_valid=%b exp=0", res_valid);
    end
    step();
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_issue2 res_valid=%b exp=0", res_valid);
    end
    step();
    got = {res_valid, res_mode, res_class, res_data};
    exp = {1'b1, 2'b01, 4'b1000, 64'h0000_0000_C328_0000};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL fp32_sign got=%h exp=%h", got, exp);
    end
    n_chk++;
    if (count !== 3'd1) begin
      n_fail++;
      $display("FAIL fp32_count got=%0d exp=1", count);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_chk++;
    if ({res_valid, count} !== 4'd0) begin
      n_fail++;
      $display("FAIL fp32_pop v=%b cnt=%0d exp 0/0", res_valid, count);
    end
  endtask

  task automatic test_fp64_special();
    do_reset();
    res_ready = 1'b1;
    do_issue(2'b10, 64'h7FF0_0000_0000_0000);
    do_issue(2'b10, 64'hFFF8_0000_0000_0001);
    step();
    n_chk++;
    if ({res_valid, res_mode, res_class, res_data} !==
        {1'b1, 2'b10, 4'b0010, 64'h7FF0_0000_0000_0000}) begin
      n_fail++;
      $display("FAIL fp64_inf v=%b m=%b c=%b d=%h",
               res_valid, res_mode, res_class, res_data);
    end
    step();
    n_chk++;
    if ({res_valid, res_mode, res_class, res_data} !==
        {1'b1, 2'b10, 4'b1100, 64'hFFF8_0000_0000_0001}) begin
      n_fail++;
      $display("FAIL fp64_nan v=%b m=%b c=%b d=%h",
               res_valid, res_mode, res_class, res_data);
    end
    step();
    res_ready = 1'b0;
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL fp64_drain got=%0d exp=0", count);
    end
  endtask

  task automatic test_fp16_mask();
    do_reset();
    res_ready = 1'b1;
    do_issue(2'b00, 64'hDEAD_BEEF_0000_7E00);
    step();
    step();
    n_chk++;
    if ({res_valid, res_mode, res_class, res_data} !==
        {1'b1, 2'b00, 4'b0100, 64'h0000_0000_0000_7E00}) begin
      n_fail++;
      $display("FAIL fp16_nan v=%b m=%b c=%b d=%h",
               res_valid, res_mode, res_class, res_data);
    end
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  m [4];
    logic [63:0] v [4];
    logic [63:0] ed [4];
    logic [3:0]  ec [4];
    m  = '{2'b11, 2'b00, 2'b01, 2'b10};
    v  = '{64'h1234_5678_9ABC_8000, 64'hFFFF_FFFF_FFFF_3C00,
           64'hAAAA_AAAA_0000_0000, 64'h8000_0000_0000_0001};
    ed = '{64'h8000, 64'h3C00, 64'h0, 64'h8000_0000_0000_0001};
    ec = '{4'b1001, 4'b0000, 4'b0001, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++)
      do_issue(m[i], v[i]);
    step();
    step();
    n_chk++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp=4", count);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({res_valid, res_mode, res_class, res_data} !==
          {1'b1, m[i], ec[i], ed[i]}) begin
        n_fail++;
        $display("FAIL b2b_%0d v=%b m=%b c=%b d=%h exp m=%b c=%b d=%h",
                 i, res_valid, res_mode, res_class, res_data,
                 m[i], ec[i], ed[i]);
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [63:0] ev;
    do_reset();
    for (int i = 0; i < 5; i++)
      do_issue(2'b01, 64'h5555_5555_3F80_0000 + 64'(i));
    step();
    step();
    n_chk++;
    if ({count, drop_err} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_state cnt=%0d drop=%b exp 4/1", count, drop_err);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev = 64'h0000_0000_3F80_0000 + 64'(i);
      n_chk++;
      if ({res_valid, res_data} !== {1'b1, ev}) begin
        n_fail++;
        $display("FAIL ovf_order_%0d v=%b d=%h exp=%h",
                 i, res_valid, res_data, ev);
      end
      step();
    end
    res_ready = 1'b0;
    n_chk++;
    if ({res_valid, count, drop_err} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sticky v=%b cnt=%0d drop=%b exp 0/0/1",
               res_valid, count, drop_err);
    end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] ev;
    do_reset();
    for (int i = 0; i < 4; i++)
      do_issue(2'b10, 64'h4000_0000_0000_0000 + 64'(i));
    step();
    do_issue(2'b10, 64'h4000_0000_0000_0004);
    step();
    n_chk++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_pre got=%0d exp=4", count);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_chk++;
    if ({count, drop_err} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_pushpop cnt=%0d drop=%b exp 4/0", count, drop_err);
    end
    res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      ev = 64'h4000_0000_0000_0000 + 64'(i);
      n_chk++;
      if ({res_valid, res_data} !== {1'b1, ev}) begin
        n_fail++;
        $display("FAIL full_order_%0d v=%b d=%h exp=%h",
                 i, res_valid, res_data, ev);
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [75:0] got;
    do_reset();
    do_issue(2'b01, 64'h0000_0000_4000_0000);
    do_issue(2'b01, 64'h0000_0000_4040_0000);
    step();
    step();
    n_chk++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_pre got=%0d exp=2", count);
    end
    do_issue(2'b00, 64'h0000_0000_0000_3C00);
    rst_n = 1'b0;
    #1;
    got = {res_valid, res_data, res_mode, res_class, count, drop_err};
    n_chk++;
    if (got !== 76'd0) begin
      n_fail++;
      $display("FAIL mid_async got=%h exp=0", got);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({res_valid, count} !== 4'd0) begin
        n_fail++;
        $display("FAIL mid_stale_%0d v=%b cnt=%0d exp 0/0",
                 i, res_valid, count);
      end
    end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_mode  = 2'b00;
    issue_val   = '0;
    res_ready   = 1'b0;
    test_reset();
    test_fp32_sign();
    test_fp64_special();
    test_fp16_mask();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
